// File: rtl/twin_pkg.sv
// Shared types and helpers for the twin ADC fault detector.
package twin_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int DATA_W_DEF = 12;

   // Widest sample the difference helper supports; narrower samples are zero-extended.
   localparam int DIFF_MAX_W = 16;

   // Unsigned absolute difference; the signed intermediate makes the sign test explicit.
   function automatic logic [DIFF_MAX_W-1:0] diff_abs(input logic [DIFF_MAX_W-1:0] a,
                                                      input logic [DIFF_MAX_W-1:0] b);
      logic signed [DIFF_MAX_W:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return (d < 0) ? DIFF_MAX_W'(-d) : DIFF_MAX_W'(d);
   endfunction

endpackage

// File: rtl/twin_fault_detect_sample_hold.sv
// One-entry holding register for a single ADC channel with full/overrun tracking.
module sample_hold
   import twin_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              accept,
   input  logic              drain,
   input  logic              valid,
   input  logic [DATA_W-1:0] sample,
   output logic [DATA_W-1:0] data,
   output logic              full,
   output logic              overrun
);

   // Control: a drain cycle empties the hold but still takes a sample arriving in that same cycle.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         full    <= 1'b0;
         overrun <= 1'b0;
      end else if (accept) begin
         if (drain) begin
            full <= valid;
         end else if (valid) begin
            if (full) overrun <= 1'b1;
            else      full    <= 1'b1;
         end
      end
   end

   // Data: capture only into an empty (or emptying) hold; a sample landing on a full hold is dropped.
   always_ff @(posedge clk) begin
      if (accept && valid && (drain || !full)) data <= sample;
   end

endmodule

// File: rtl/twin_fault_detect.sv
// Window-based comparison of a circuit-under-test ADC stream against its healthy twin.
module twin_fault_detect
   import twin_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  WINDOW = 10,
   parameter int  THRESH = 64,
   parameter int  CONSEC = 3,
   localparam int CNT_W  = $clog2(WINDOW + 1),
   localparam int RUN_W  = $clog2(CONSEC + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] sample_a,
   input  logic              valid_a,
   input  logic [DATA_W-1:0] sample_b,
   input  logic              valid_b,
   output logic              busy,
   output logic              done,
   output logic              fault,
   output logic              overrun,
   output logic [CNT_W-1:0]  mismatch_cnt,
   output logic [DATA_W-1:0] max_diff
);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   hold_a, hold_b;
   logic                full_a, full_b, ovr_a, ovr_b;
   logic                clr, accept, drain, last_pair;
   logic [CNT_W-1:0]    pair_cnt;
   logic [RUN_W-1:0]    run_cnt, run_next_p0;
   logic [DATA_W-1:0]   diff_p0;
   logic                hit_p0;

   // Run length of consecutive mismatches, pinned at CONSEC once reached.
   function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] r);
      return (r >= RUN_W'(CONSEC)) ? RUN_W'(CONSEC) : r + RUN_W'(1);
   endfunction

   assign clr     = (state_q == IDLE) && start;
   assign accept  = (state_q == COLLECT) || (state_q == COMPARE);
   assign drain   = (state_q == COMPARE);
   assign busy    = accept;
   assign done    = (state_q == DONE);
   assign overrun = ovr_a | ovr_b;

   sample_hold #(.DATA_W(DATA_W)) u_hold_a (
      .clk(clk), .rst(rst), .clr(clr), .accept(accept), .drain(drain),
      .valid(valid_a), .sample(sample_a), .data(hold_a), .full(full_a), .overrun(ovr_a)
   );

   sample_hold #(.DATA_W(DATA_W)) u_hold_b (
      .clk(clk), .rst(rst), .clr(clr), .accept(accept), .drain(drain),
      .valid(valid_b), .sample(sample_b), .data(hold_b), .full(full_b), .overrun(ovr_b)
   );

   // Stage p0: difference of the held pair, evaluated during COMPARE
   assign diff_p0     = DATA_W'(diff_abs(DIFF_MAX_W'(hold_a), DIFF_MAX_W'(hold_b)));
   assign hit_p0      = diff_p0 > DATA_W'(THRESH);
   assign run_next_p0 = hit_p0 ? sat_run(run_cnt) : '0;
   assign last_pair   = (pair_cnt == CNT_W'(WINDOW - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state: COMPARE is entered on the same edge that fills the second hold.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = COLLECT;
         COLLECT: if ((full_a || valid_a) && (full_b || valid_b)) state_d = COMPARE;
         COMPARE: state_d = last_pair ? DONE : COLLECT;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Window statistics: cleared on reset or window start, updated once per COMPARE.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pair_cnt     <= '0;
         run_cnt      <= '0;
         mismatch_cnt <= '0;
         max_diff     <= '0;
         fault        <= 1'b0;
      end else if (state_q == COMPARE) begin
         pair_cnt <= pair_cnt + CNT_W'(1);
         run_cnt  <= run_next_p0;
         if (hit_p0)                          mismatch_cnt <= mismatch_cnt + CNT_W'(1);
         if (diff_p0 > max_diff)              max_diff     <= diff_p0;
         if (run_next_p0 == RUN_W'(CONSEC))   fault        <= 1'b1;
      end
   end

endmodule

// File: tb/tb_twin_fault_detect.sv
// Scoreboard bench for twin_fault_detect: window results are predicted as pairs are driven.
module tb_twin_fault_detect;

   logic        clk = 1'b0;
   logic        rst, start, valid_a, valid_b;
   logic [11:0] sample_a, sample_b;
   logic        busy, done, fault, overrun;
   logic [3:0]  mismatch_cnt;
   logic [11:0] max_diff;

   typedef struct packed {
      logic        fault;
      logic        overrun;
      logic [3:0]  mis;
      logic [11:0] maxd;
   } res_t;

   res_t sb_q[$];
   res_t exp_r;
   int   n_vec = 0;
   int   n_err = 0;
   int   m_mis, m_max, m_run;
   logic m_fault, m_ovr;

   always #10 clk = ~clk;

   twin_fault_detect dut (
      .clk(clk), .rst(rst), .start(start),
      .sample_a(sample_a), .valid_a(valid_a),
      .sample_b(sample_b), .valid_b(valid_b),
      .busy(busy), .done(done), .fault(fault), .overrun(overrun),
      .mismatch_cnt(mismatch_cnt), .max_diff(max_diff)
   );

   // Result monitor: every done pulse retires one predicted window.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_done: done=1 with no window outstanding at %0t", $time);
         end else begin
            exp_r = sb_q.pop_front();
            n_vec++;
            if (fault !== exp_r.fault) begin
               n_err++; $display("FAIL win_fault: got %0b want %0b", fault, exp_r.fault);
            end
            n_vec++;
            if (overrun !== exp_r.overrun) begin
               n_err++; $display("FAIL win_overrun: got %0b want %0b", overrun, exp_r.overrun);
            end
            n_vec++;
            if (mismatch_cnt !== exp_r.mis) begin
               n_err++; $display("FAIL win_mismatch_cnt: got %0d want %0d", mismatch_cnt, exp_r.mis);
            end
            n_vec++;
            if (max_diff !== exp_r.maxd) begin
               n_err++; $display("FAIL win_max_diff: got %0d want %0d", max_diff, exp_r.maxd);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic va, input logic [11:0] a, input logic vb, input logic [11:0] b);
      valid_a = va; sample_a = a; valid_b = vb; sample_b = b;
      @(posedge clk); #1;
      valid_a = 1'b0; valid_b = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic model_clear();
      m_mis = 0; m_max = 0; m_run = 0; m_fault = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic model_pair(input logic [11:0] a, input logic [11:0] b);
      int d;
      d = (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
      if (d > m_max) m_max = d;
      if (d > 64) begin
         m_mis++;
         if (m_run < 3) m_run++;
      end else begin
         m_run = 0;
      end
      if (m_run == 3) m_fault = 1'b1;
   endtask

   // Both channels in the same cycle, then the COMPARE cycle.
   task automatic send_pair(input logic [11:0] a, input logic [11:0] b);
      drive(1'b1, a, 1'b1, b);
      idle(1);
      model_pair(a, b);
   endtask

   task automatic start_window(input string name);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      model_clear();
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL %s_busy_rise: got %0b want 1", name, busy);
      end
   endtask

   task automatic push_expected();
      sb_q.push_back({m_fault, m_ovr, 4'(m_mis), 12'(m_max)});
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 100) begin
         @(posedge clk); #1; k++;
      end
      if (sb_q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout: no done within 100 cycles, outstanding=%0d want 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
      sample_a = '0; sample_b = '0;
      idle(3);
      n_vec++;
      if ({busy, done, fault, overrun, mismatch_cnt, max_diff} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got busy=%0b done=%0b fault=%0b ovr=%0b mis=%0d max=%0d want all 0",
                  busy, done, fault, overrun, mismatch_cnt, max_diff);
      end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_equal();
      start_window("equal");
      for (int p = 0; p < 10; p++) send_pair(12'h800, 12'h800);
      push_expected();
      wait_done("equal");
      idle(2);
      n_vec++;
      if (busy !== 1'b0 || mismatch_cnt !== 4'd0) begin
         n_err++; $display("FAIL equal_hold: got busy=%0b mis=%0d want busy=0 mis=0", busy, mismatch_cnt);
      end
   endtask

   task automatic test_fault_run();
      start_window("fault");
      for (int p = 1; p <= 10; p++) begin
         if (p >= 3 && p <= 5) send_pair(12'h800, 12'h7B0);
         else                  send_pair(12'h800, 12'h800);
         if (p == 4) begin
            n_vec++;
            if (fault !== 1'b0) begin
               n_err++; $display("FAIL fault_early: got %0b want 0 after pair 4", fault);
            end
         end
         if (p == 5) begin
            n_vec++;
            if (fault !== m_fault || mismatch_cnt !== 4'(m_mis)) begin
               n_err++; $display("FAIL fault_edge: got fault=%0b mis=%0d want fault=%0b mis=%0d",
                                 fault, mismatch_cnt, m_fault, m_mis);
            end
         end
         if (p == 6) begin
            start = 1'b1;
            idle(1);
            start = 1'b0;
         end
      end
      push_expected();
      wait_done("fault");
   endtask

   task automatic test_thresh();
      start_window("thresh64");
      for (int p = 0; p < 10; p++) begin
         if (p % 2 == 0) send_pair(12'h500, 12'h540);
         else            send_pair(12'h540, 12'h500);
      end
      push_expected();
      wait_done("thresh64");
      start_window("thresh65");
      for (int p = 0; p < 10; p++) begin
         if (p % 3 == 2)      send_pair(12'h300, 12'h300);
         else if (p % 2 == 0) send_pair(12'h300, 12'h300 + 12'd65);
         else                 send_pair(12'h300, 12'h300 - 12'd65);
      end
      push_expected();
      wait_done("thresh65");
   endtask

   task automatic test_overrun();
      start_window("overrun");
      drive(1'b1, 12'h100, 1'b0, 12'h000);
      drive(1'b1, 12'h200, 1'b0, 12'h000);
      n_vec++;
      if (overrun !== 1'b1) begin
         n_err++; $display("FAIL overrun_flag: got %0b want 1", overrun);
      end
      drive(1'b0, 12'h000, 1'b1, 12'h100);
      idle(1);
      m_ovr = 1'b1;
      model_pair(12'h100, 12'h100);
      for (int p = 1; p < 10; p++) send_pair(12'h100, 12'h100);
      push_expected();
      wait_done("overrun");
   endtask

   task automatic test_back_to_back();
      logic [11:0] a1, b1, a2, b2;
      start_window("b2b");
      for (int i = 0; i < 5; i++) begin
         a1 = 12'($urandom_range(1000, 3000));
         b1 = ($urandom_range(0, 1) == 1) ? a1 + 12'($urandom_range(0, 120)) : a1 - 12'($urandom_range(0, 120));
         a2 = 12'($urandom_range(1000, 3000));
         b2 = ($urandom_range(0, 1) == 1) ? a2 + 12'($urandom_range(0, 120)) : a2 - 12'($urandom_range(0, 120));
         drive(1'b1, a1, 1'b1, b1);
         drive(1'b1, a2, 1'b0, 12'h000);
         drive(1'b0, 12'h000, 1'b1, b2);
         idle(1);
         model_pair(a1, b1);
         model_pair(a2, b2);
      end
      push_expected();
      wait_done("b2b");
   endtask

   task automatic test_reset_mid();
      start_window("rstmid");
      for (int p = 1; p <= 6; p++) begin
         if (p >= 2 && p <= 4) send_pair(12'h400, 12'h464);
         else                  send_pair(12'h400, 12'h400);
      end
      n_vec++;
      if (fault !== m_fault) begin
         n_err++; $display("FAIL rstmid_fault: got %0b want %0b", fault, m_fault);
      end
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      n_vec++;
      if ({busy, done, fault, overrun, mismatch_cnt, max_diff} !== '0) begin
         n_err++;
         $display("FAIL rstmid_outputs: got busy=%0b done=%0b fault=%0b ovr=%0b mis=%0d max=%0d want all 0",
                  busy, done, fault, overrun, mismatch_cnt, max_diff);
      end
      for (int p = 0; p < 12; p++) send_pair(12'h400, 12'h4FF);
      idle(10);
      n_vec++;
      if (busy !== 1'b0 || max_diff !== 12'd0) begin
         n_err++; $display("FAIL rstmid_idle: got busy=%0b max=%0d want busy=0 max=0", busy, max_diff);
      end
      start_window("post_rst");
      for (int p = 0; p < 10; p++) send_pair(12'h600, 12'h605);
      push_expected();
      wait_done("post_rst");
   endtask

   initial begin
      test_reset();
      test_equal();
      test_fault_run();
      test_thresh();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
